alu_wb_queue: RTL
=================

Name: alu_wb_queue

Overview:
Writeback buffer directly downstream of the ALU execute stage. It captures each registered ALU result together with its ROB tag and destination physical register, and holds them in a small in-order FIFO. It then presents the oldest entry to the common data bus (CDB) arbiter. If the CDB is granted to another unit, the ALU keeps issuing until this queue fills, and it is then back-pressured through in_ready.

Parameters:
DEPTH, 4, number of buffered results; must be a power of two and at least 2.
DATA_W, 32, width of the result datapath.
TAG_W, 6, ROB tag width.
PREG_W, 7, physical destination register index width.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
valid_in  input  1  ALU result this cycle is valid.
result_in  input  DATA_W  ALU result.
rob_tag_in  input  TAG_W  ROB tag of the producing instruction.
prd_in  input  PREG_W  destination physical register.
reg_write_in  input  1  instruction writes a register.
in_ready  output  1  queue can accept a push this cycle.
flush  input  1  synchronous squash of all entries (branch mispredict).
cdb_valid  output  1  head entry is valid and requesting the CDB.
cdb_grant  input  1  arbiter accepts the head entry this cycle.
cdb_result  output  DATA_W  head result.
cdb_rob_tag  output  TAG_W  head ROB tag.
cdb_prd  output  PREG_W  head destination register.
cdb_reg_write  output  1  head register-write flag.
count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage is a circular buffer with a read pointer and a write pointer, each clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. Occupancy is kept in a separate counter of width clog2(DEPTH)+1.
- Reset (rst=0, asynchronous): pointers=0, count=0, all entry valid bits=0.
  - Resulting outputs: cdb_valid=0, in_ready=1, cdb_result=0, cdb_rob_tag=0, cdb_prd=0, cdb_reg_write=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
  - Reset deassertion is synchronised by the system; the block needs no internal synchroniser.
- in_ready = (count != DEPTH). It is combinational from count and does not depend on cdb_grant, so there is no pass-through when full.
- Push = valid_in & in_ready & ~flush. On push, the entry is written at the write pointer and the write pointer increments.
- Pop = cdb_valid & cdb_grant & ~flush. On pop, the read pointer increments.
- cdb_valid = (count != 0). The cdb_* data outputs are driven combinationally from the entry at the read pointer and read 0 when the queue is empty.
- A cdb_grant with cdb_valid=0 is ignored.
- Latency: a result pushed at edge N is visible on cdb_* immediately after edge N. Minimum valid_in-to-CDB latency is therefore one cycle.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any occupancy from 1 to DEPTH-1. At DEPTH, in_ready=0 blocks the push, so only the pop occurs.
- Order is strictly FIFO; no reordering by tag.
- flush=1 at an edge: pointers=0, count=0. Flush overrides a same-cycle push and pop; the incoming valid_in result is dropped.
- valid_in while in_ready=0: the upstream stage must hold its data. The queue does not capture it, and no error is raised.
- count never exceeds DEPTH and never underflows.

Test Plan:
1. Reset and single result. Hold rst=0 for 2 cycles, then release. Push result 0x0000_0005, tag 3, prd 10, with cdb_grant=1. -> cdb_valid=1 with those values on the following cycle. Next cycle cdb_valid=0 and count=0.
2. Fill and back-pressure. With cdb_grant=0, push 5 results (0x11, 0x22, 0x33, 0x44, 0x55). -> in_ready drops after the 4th push, count=4, and 0x55 is not captured. Then hold grant=1 for 4 cycles -> CDB presents 0x11, 0x22, 0x33, 0x44 in order, then cdb_valid=0.
3. Wrap-around with simultaneous push/pop. Stream 10 results with valid_in=1 and cdb_grant=1 every cycle. -> count stays at 1 after the first push, all 10 appear in order, and the pointers wrap twice.
4. Flush priority. With count=3, assert flush together with valid_in and cdb_grant. -> next cycle count=0, cdb_valid=0, in_ready=1, and the flushed and incoming results never appear.
5. Asynchronous reset mid-operation. With count=2, drive rst=0 between clock edges. -> cdb_valid=0 and count=0 before the next rising edge. After release, a new push of tag 7 appears correctly.
6. Spurious grant. Assert cdb_grant=1 while empty. -> pointers and count are unchanged. A later push is presented with correct data.

Source files
------------

// File: rtl/alu_wb_queue.sv
// ALU writeback queue: in-order FIFO of ALU results (result, ROB tag, dest preg,
// reg-write flag) that presents its oldest entry to the CDB arbiter and back-pressures
// the ALU through in_ready when full. Flush squashes every entry.
module alu_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned PREG_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       result_in,
  input  logic [TAG_W-1:0]        rob_tag_in,
  input  logic [PREG_W-1:0]       prd_in,
  input  logic                    reg_write_in,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    cdb_valid,
  input  logic                    cdb_grant,
  output logic [DATA_W-1:0]       cdb_result,
  output logic [TAG_W-1:0]        cdb_rob_tag,
  output logic [PREG_W-1:0]       cdb_prd,
  output logic                    cdb_reg_write,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [DATA_W-1:0] result_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem    [DEPTH];
  logic [PREG_W-1:0] prd_mem    [DEPTH];
  logic [DEPTH-1:0]  rw_mem;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop, head_vld;

  // Handshakes: no pass-through when full, and flush kills both sides of the cycle.
  assign in_ready  = (count_q != Full);
  assign cdb_valid = (count_q != '0);
  assign push      = valid_in & in_ready & ~flush;
  assign pop       = cdb_valid & cdb_grant & ~flush;
  assign head_vld  = cdb_valid & vld_q[rd_ptr_q];
  assign count     = count_q;

  // Head entry drives the CDB directly; data reads as zero when nothing is held.
  assign cdb_result    = head_vld ? result_mem[rd_ptr_q] : '0;
  assign cdb_rob_tag   = head_vld ? tag_mem[rd_ptr_q]    : '0;
  assign cdb_prd       = head_vld ? prd_mem[rd_ptr_q]    : '0;
  assign cdb_reg_write = head_vld & rw_mem[rd_ptr_q];

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      vld_d    = '0;
    end else begin
      // Push and pop never hit the same slot: that needs count==0 or count==DEPTH.
      if (push) begin
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
        vld_d[wr_ptr_q] = 1'b1;
      end
      if (pop) begin
        rd_ptr_d        = rd_ptr_q + PtrW'(1);
        vld_d[rd_ptr_q] = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage; never reset because outputs are gated by the valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr_q] <= result_in;
      tag_mem[wr_ptr_q]    <= rob_tag_in;
      prd_mem[wr_ptr_q]    <= prd_in;
      rw_mem[wr_ptr_q]     <= reg_write_in;
    end
  end

endmodule
